// File: rtl/bcd_binary_decoder_if.sv
// ---------------------------------------------------------------------------
// bcd_binary_decoder_if
// Bundle of the BCD-to-binary converter's request and result signals.
//   convert      : start strobe (master -> slave)
//   bcd_in       : packed BCD digits, digit i at [i*4+:4] (master -> slave)
//   busy         : conversion in progress (slave -> master)
//   done         : one-cycle pulse, result outputs just updated (slave -> master)
//   bin_out      : converted binary value (slave -> master)
//   bcd_error    : last conversion held a digit above 9 (slave -> master)
//   bin_overflow : last conversion did not fit in bin_out (slave -> master)
// ---------------------------------------------------------------------------
interface bcd_binary_decoder_if #(
  parameter int BCD_DIGITS = 5,
  parameter int BIN_WIDTH  = 17
);
  logic                    convert;
  logic [BCD_DIGITS*4-1:0] bcd_in;
  logic                    busy;
  logic                    done;
  logic [BIN_WIDTH-1:0]    bin_out;
  logic                    bcd_error;
  logic                    bin_overflow;

  modport master (
    output convert, bcd_in,
    input  busy, done, bin_out, bcd_error, bin_overflow
  );

  modport slave (
    input  convert, bcd_in,
    output busy, done, bin_out, bcd_error, bin_overflow
  );
endinterface

// File: rtl/bcd_binary_decoder.sv
// ---------------------------------------------------------------------------
// bcd_binary_decoder
// Sequential BCD-to-binary converter. A convert strobe in IDLE captures the
// packed digits; one digit per clock (most significant first) is folded into
// acc = acc*10 + digit; a final cycle publishes the registered result with a
// one-cycle done pulse.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of bcd_binary_decoder_if (see interface header)
// ---------------------------------------------------------------------------
module bcd_binary_decoder #(
  parameter int BCD_DIGITS = 5,
  parameter int BIN_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_binary_decoder_if.slave   bus
);

  localparam int SHIFT_W = BCD_DIGITS * 4;
  localparam int ACC_W   = BIN_WIDTH + 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [2:0]           LAST_DIGIT = 3'(BCD_DIGITS - 1);
  // 2^BIN_WIDTH: parking value once the result is known not to fit
  localparam logic [ACC_W-1:0]     ACC_SAT    = {3'b000, 1'b1, {BIN_WIDTH{1'b0}}};
  localparam logic [BIN_WIDTH-1:0] BIN_ONES   = {BIN_WIDTH{1'b1}};
  localparam logic [BIN_WIDTH-1:0] BIN_ZERO   = {BIN_WIDTH{1'b0}};

  logic [1:0]           state_r;
  logic [SHIFT_W-1:0]   shift_r;
  logic [ACC_W-1:0]     acc_r;
  logic [2:0]           cnt_r;
  logic                 err_r;
  logic                 ovf_r;
  logic                 busy_r;
  logic                 done_r;
  logic [BIN_WIDTH-1:0] bin_out_r;
  logic                 bcd_error_r;
  logic                 bin_overflow_r;

  logic [3:0]           digit_s;
  logic [ACC_W-1:0]     step_s;
  logic                 step_ovf_s;

  // One accumulation step: acc*10 + top digit. acc never exceeds 2^BIN_WIDTH,
  // so acc*10 + 15 always fits in ACC_W bits and the step cannot wrap.
  always_comb begin
    digit_s    = shift_r[SHIFT_W-1 -: 4];
    step_s     = {acc_r[ACC_W-4:0], 3'b000}
               + {acc_r[ACC_W-2:0], 1'b0}
               + {{(ACC_W-4){1'b0}}, digit_s};
    step_ovf_s = |step_s[ACC_W-1:BIN_WIDTH];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      shift_r        <= {SHIFT_W{1'b0}};
      acc_r          <= {ACC_W{1'b0}};
      cnt_r          <= 3'd0;
      err_r          <= 1'b0;
      ovf_r          <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      bin_out_r      <= BIN_ZERO;
      bcd_error_r    <= 1'b0;
      bin_overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.convert) begin
            shift_r <= bus.bcd_in;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= 3'd0;
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_ACCUM;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ACCUM: begin
          shift_r <= shift_r << 3'd4;
          cnt_r   <= cnt_r + 3'd1;
          // invalid digits are flagged but still enter the arithmetic as-is
          if (digit_s > 4'd9) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
          if (step_ovf_s) begin
            acc_r <= ACC_SAT;
            ovf_r <= 1'b1;
          end else begin
            acc_r <= step_s;
          end
          if (cnt_r == LAST_DIGIT) begin
            state_r <= ST_FINISH;
          end else begin
            state_r <= ST_ACCUM;
          end
        end

        ST_FINISH: begin
          // a digit error takes precedence over saturation
          if (err_r) begin
            bin_out_r <= BIN_ZERO;
          end else if (ovf_r) begin
            bin_out_r <= BIN_ONES;
          end else begin
            bin_out_r <= acc_r[BIN_WIDTH-1:0];
          end
          bcd_error_r    <= err_r;
          bin_overflow_r <= ovf_r;
          done_r         <= 1'b1;
          busy_r         <= 1'b0;
          state_r        <= ST_IDLE;
        end

        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.bin_out      = bin_out_r;
  assign bus.bcd_error    = bcd_error_r;
  assign bus.bin_overflow = bin_overflow_r;

endmodule
